// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_add_pkg;

    // Sequencer states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the serial adder.
interface serial_adder_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout
    );

    // Adder side.
    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_full_add_cell.sv
// Single-bit full adder made of two half-adder stages and a carry OR.
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum_s;
    logic ha0_carry_s;
    logic ha1_carry_s;

    // First half adder on the operand bits, second folds in the carry.
    always_comb begin
        ha0_sum_s   = a ^ b;
        ha0_carry_s = a & b;
        sum         = ha0_sum_s ^ cin;
        ha1_carry_s = ha0_sum_s & cin;
        cout        = ha0_carry_s | ha1_carry_s;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add cell, carry held in a flop,
// operands consumed LSB-first over WIDTH cycles.
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_if.slave        bus
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    // Only the upper WIDTH-1 bits of the sum shifter are stored: the
    // lowest bit would be shifted out on the final step anyway.
    logic [WIDTH-2:0] s_sr_q;
    logic             c_ff_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] s_next_s;

    full_add_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_ff_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // New sum bit enters at the MSB; after WIDTH steps this is the full result.
    always_comb begin
        s_next_s = {fa_sum_s, s_sr_q};
    end

    // Sequencer: operand capture, per-bit shift/accumulate, result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_ff_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr_q  <= bus.op_a;
                        b_sr_q  <= bus.op_b;
                        c_ff_q  <= bus.cin;
                        s_sr_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
                    s_sr_q <= s_next_s[WIDTH-1:1];
                    c_ff_q <= fa_cout_s;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        sum_q   <= s_next_s;
                        cout_q  <= fa_cout_s;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 and WIDTH=5.
module tb_serial_adder;
    import serial_add_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(5)) bus5 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; returns {cout,sum}, steps from start edge to done, busy cycles.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [8:0] res, output int lat, output int busy_n);
        bus8.op_a = a; bus8.op_b = b; bus8.cin = c; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        lat = 0; busy_n = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (bus8.busy === 1'b1) busy_n++;
            step();
            lat++;
        end
        res = {bus8.cout, bus8.sum};
        step();
    endtask

    task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic c,
                        output logic [5:0] res, output int lat);
        bus5.op_a = a; bus5.op_b = b; bus5.cin = c; bus5.start = 1'b1;
        step();
        bus5.start = 1'b0;
        lat = 0;
        while (bus5.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        res = {bus5.cout, bus5.sum};
        step();
    endtask

    initial begin
        logic [8:0] r8;
        logic [5:0] r5;
        logic [8:0] e8;
        logic [5:0] e5;
        logic [7:0] ra, rb;
        logic [4:0] sa, sb;
        logic       rc;
        int         lat, bn, n, p, dn;

        rst = 1'b1;
        bus8.start = 1'b0; bus8.op_a = 8'h00; bus8.op_b = 8'h00; bus8.cin = 1'b0;
        bus5.start = 1'b0; bus5.op_a = 5'h00; bus5.op_b = 5'h00; bus5.cin = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state.
        chk("rst_busy", 32'(bus8.busy), 32'h0);
        chk("rst_done", 32'(bus8.done), 32'h0);
        chk("rst_sum_cout", 32'({bus8.cout, bus8.sum}), 32'h0);
        chk("rst5_sum_cout", 32'({bus5.cout, bus5.sum}), 32'h0);

        // 0x0F + 0x01: latency, busy length, result, post-done status.
        run8(8'h0F, 8'h01, 1'b0, r8, lat, bn);
        chk("t1_lat", 32'(lat), 32'd8);
        chk("t1_busy_cycles", 32'(bn), 32'd8);
        chk("t1_res", 32'(r8), 32'h010);
        chk("t1_done_after", 32'(bus8.done), 32'h0);
        chk("t1_busy_after", 32'(bus8.busy), 32'h0);

        // Carry-out boundaries.
        run8(8'hFF, 8'h01, 1'b0, r8, lat, bn);
        chk("t2_res", 32'(r8), 32'h100);
        run8(8'hFF, 8'hFF, 1'b1, r8, lat, bn);
        chk("t3_res", 32'(r8), 32'h1FF);

        // Second start during RUN is ignored.
        bus8.op_a = 8'h0F; bus8.op_b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        step(); step();
        bus8.op_a = 8'h55; bus8.op_b = 8'h00; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        dn = 0; r8 = 9'h000;
        for (int i = 0; i < 15; i++) begin
            if (bus8.done === 1'b1) begin
                dn++;
                r8 = {bus8.cout, bus8.sum};
            end
            step();
        end
        chk("t4_done_count", 32'(dn), 32'd1);
        chk("t4_res", 32'(r8), 32'h010);

        // Start held high: back-to-back operations, period WIDTH+2.
        bus8.op_a = 8'h01; bus8.op_b = 8'h02; bus8.cin = 1'b0; bus8.start = 1'b1;
        step();
        bus8.op_a = 8'h10; bus8.op_b = 8'h20;
        n = 0;
        while (bus8.done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("t5_lat", 32'(n), 32'd8);
        chk("t5_res1", 32'({bus8.cout, bus8.sum}), 32'h003);
        p = 0;
        do begin
            step();
            p++;
        end while (bus8.done !== 1'b1 && p < 40);
        chk("t5_period", 32'(p), 32'd10);
        chk("t5_res2", 32'({bus8.cout, bus8.sum}), 32'h030);
        bus8.start = 1'b0;
        step();

        // Reset during the 4th RUN cycle discards the operation.
        bus8.op_a = 8'hAA; bus8.op_b = 8'h11; bus8.cin = 1'b1; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        step(); step(); step();
        chk("t6_busy_before", 32'(bus8.busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy", 32'(bus8.busy), 32'h0);
        chk("t6_done", 32'(bus8.done), 32'h0);
        chk("t6_sum_cout", 32'({bus8.cout, bus8.sum}), 32'h0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done === 1'b1) dn++;
            step();
        end
        chk("t6_no_done", 32'(dn), 32'd0);
        run8(8'h7F, 8'h01, 1'b0, r8, lat, bn);
        chk("t6_after_res", 32'(r8), 32'h080);

        // Random sweep, WIDTH=8.
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rc = 1'($urandom_range(1, 0));
            e8 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            run8(ra, rb, rc, r8, lat, bn);
            chk("rand8_res", 32'(r8), 32'(e8));
            chk("rand8_lat", 32'(lat), 32'd8);
        end

        // Random sweep, WIDTH=5.
        for (int i = 0; i < 200; i++) begin
            sa = 5'($urandom_range(31, 0));
            sb = 5'($urandom_range(31, 0));
            rc = 1'($urandom_range(1, 0));
            e5 = {1'b0, sa} + {1'b0, sb} + {5'h00, rc};
            run5(sa, sb, rc, r5, lat);
            chk("rand5_res", 32'(r5), 32'(e5));
            chk("rand5_lat", 32'(lat), 32'd5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
